// File: rtl/quiz_pkg.sv
// Shared definitions for the factorization-quiz control blocks:
// arbiter state encoding, player indices and one-hot grant codes.
package quiz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_ANSWER = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_P0   = 2'b01;
  localparam logic [1:0] GRANT_P1   = 2'b10;

  function automatic logic [1:0] player_onehot(input logic player);
    return (player == P1) ? GRANT_P1 : GRANT_P0;
  endfunction

endpackage

// File: rtl/buzz_arbiter_if.sv
// Handshake bundle between the game controller / buttons and the buzz arbiter.
interface buzz_arbiter_if;

  logic       ENABLE;
  logic [1:0] REQ;
  logic       DONE;
  logic       RESULT;
  logic [1:0] GRANT;
  logic       BUSY;
  logic       TIMEOUT;
  logic [1:0] WINNER;
  logic [1:0] LOCKED;
  logic [3:0] SEC_LEFT;

  modport master (
    output ENABLE, REQ, DONE, RESULT,
    input  GRANT, BUSY, TIMEOUT, WINNER, LOCKED, SEC_LEFT
  );

  modport slave (
    input  ENABLE, REQ, DONE, RESULT,
    output GRANT, BUSY, TIMEOUT, WINNER, LOCKED, SEC_LEFT
  );

endinterface

// File: rtl/sec_tick.sv
// One-second prescaler: TICK is high for one cycle every CLK_HZ cycles.
// RESTART zeroes the count so the next tick lands exactly CLK_HZ cycles later.
module sec_tick #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic RESTART,
  output logic TICK
);

  localparam int unsigned     CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (RESTART || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/buzz_arbiter.sv
// Two-player buzzer arbiter: first press wins input rights, answer window is
// timed, wrong/expired answers lock the player out for a penalty period.
module buzz_arbiter
  import quiz_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned ANSWER_SEC  = 10,
  parameter int unsigned PENALTY_SEC = 3
) (
  input  logic           CLK,
  input  logic           RST_N,
  buzz_arbiter_if.slave  bus
);

  localparam logic [3:0] ANS_LOAD = 4'(ANSWER_SEC);
  // One extra count because the penalty runs on the free-running tick,
  // so the first decrement may arrive almost immediately.
  localparam logic [4:0] PEN_LOAD = 5'(PENALTY_SEC + 1);

  state_t     state;
  logic [1:0] req_q;
  logic [1:0] grant_q;
  logic [1:0] winner_q;
  logic       busy_q;
  logic       timeout_q;
  logic [3:0] sec_q;
  logic [4:0] pen_cnt [2];
  logic       ptr;

  logic       free_tick;
  logic       ans_tick;
  logic [1:0] locked;
  logic [1:0] press;
  logic       grant_fire;
  logic       grant_player;

  assign locked[P0] = (pen_cnt[P0] != '0);
  assign locked[P1] = (pen_cnt[P1] != '0);

  assign press      = bus.REQ & ~req_q & ~locked;
  assign grant_fire = (state == ST_OPEN) && bus.ENABLE && (press != GRANT_NONE);

  always_comb begin
    grant_player = ptr;
    if (press == GRANT_P0) begin
      grant_player = P0;
    end else if (press == GRANT_P1) begin
      grant_player = P1;
    end
  end

  sec_tick #(.CLK_HZ(CLK_HZ)) u_free_tick (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .RESTART (1'b0),
    .TICK    (free_tick)
  );

  sec_tick #(.CLK_HZ(CLK_HZ)) u_answer_tick (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .RESTART (grant_fire),
    .TICK    (ans_tick)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      req_q       <= '0;
      grant_q     <= GRANT_NONE;
      winner_q    <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      sec_q       <= '0;
      pen_cnt[P0] <= '0;
      pen_cnt[P1] <= '0;
      ptr         <= P0;
    end else begin
      req_q     <= bus.REQ;
      timeout_q <= 1'b0;
      winner_q  <= '0;

      if (free_tick && pen_cnt[P0] != '0) pen_cnt[P0] <= pen_cnt[P0] - 5'd1;
      if (free_tick && pen_cnt[P1] != '0) pen_cnt[P1] <= pen_cnt[P1] - 5'd1;

      case (state)
        ST_IDLE: begin
          pen_cnt[P0] <= '0;
          pen_cnt[P1] <= '0;
          if (bus.ENABLE) state <= ST_OPEN;
        end

        ST_OPEN: begin
          if (!bus.ENABLE) begin
            state <= ST_IDLE;
          end else if (grant_fire) begin
            grant_q <= player_onehot(grant_player);
            busy_q  <= 1'b1;
            sec_q   <= ANS_LOAD;
            ptr     <= ~grant_player;
            state   <= ST_ANSWER;
          end
        end

        ST_ANSWER: begin
          // ENABLE loss outranks DONE, which outranks the expiry tick.
          if (!bus.ENABLE) begin
            grant_q <= GRANT_NONE;
            busy_q  <= 1'b0;
            sec_q   <= '0;
            state   <= ST_IDLE;
          end else if (bus.DONE) begin
            grant_q <= GRANT_NONE;
            busy_q  <= 1'b0;
            sec_q   <= '0;
            if (bus.RESULT) begin
              winner_q <= grant_q;
              state    <= ST_SETTLE;
            end else begin
              pen_cnt[grant_q[1]] <= PEN_LOAD;
              state               <= ST_OPEN;
            end
          end else if (ans_tick) begin
            if (sec_q == 4'd1) begin
              grant_q             <= GRANT_NONE;
              busy_q              <= 1'b0;
              sec_q               <= '0;
              timeout_q           <= 1'b1;
              pen_cnt[grant_q[1]] <= PEN_LOAD;
              state               <= ST_OPEN;
            end else begin
              sec_q <= sec_q - 4'd1;
            end
          end
        end

        ST_SETTLE: begin
          if (!bus.ENABLE) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.GRANT    = grant_q;
  assign bus.BUSY     = busy_q;
  assign bus.TIMEOUT  = timeout_q;
  assign bus.WINNER   = winner_q;
  assign bus.LOCKED   = locked;
  assign bus.SEC_LEFT = sec_q;

endmodule

// File: tb/tb_buzz_arbiter.sv
// Bench for buzz_arbiter: deadline/lock-window model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_buzz_arbiter;

  localparam int HZ  = 10;
  localparam int ANS = 3;
  localparam int PEN = 2;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;

  buzz_arbiter_if bus ();

  buzz_arbiter #(
    .CLK_HZ      (HZ),
    .ANSWER_SEC  (ANS),
    .PENALTY_SEC (PEN)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: absolute edge counts, deadlines, lock windows
  int k = 0;
  int g = 0;
  int ph = 0;            // 0 idle, 1 open, 2 answer, 3 settle
  int owner = -1;
  int ptr_m = 0;
  int pick = 0;
  int lock_end [2] = '{0, 0};
  logic [1:0] prev_req = '0;
  logic [1:0] m_press  = '0;
  logic [1:0] e_grant  = '0;
  logic [1:0] e_winner = '0;
  logic [1:0] e_locked = '0;
  logic       e_busy   = 1'b0;
  logic       e_timeout = 1'b0;
  logic [3:0] e_sec    = '0;

  function automatic logic [1:0] oh(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  // Penalty ends at the (PEN+1)-th free second boundary after the lock edge.
  function automatic int unlock_edge(input int e);
    return (e / HZ + PEN + 1) * HZ;
  endfunction

  task automatic model_update();
    if (!RST_N) begin
      k = 0; g = 0; ph = 0; owner = -1; ptr_m = 0;
      lock_end[0] = 0; lock_end[1] = 0; prev_req = '0;
      e_grant = '0; e_winner = '0; e_locked = '0;
      e_busy = 1'b0; e_timeout = 1'b0; e_sec = '0;
    end else begin
      k++;
      e_timeout = 1'b0;
      e_winner  = '0;
      m_press = bus.REQ & ~prev_req;
      for (int i = 0; i < 2; i++) if ((k - 1) < lock_end[i]) m_press[i] = 1'b0;
      case (ph)
        0: begin
          lock_end[0] = 0; lock_end[1] = 0;
          if (bus.ENABLE) ph = 1;
        end
        1: begin
          if (!bus.ENABLE) ph = 0;
          else if (m_press != 2'b00) begin
            pick  = (m_press == 2'b11) ? ptr_m : (m_press[1] ? 1 : 0);
            owner = pick; g = k; ptr_m = 1 - pick; ph = 2;
          end
        end
        2: begin
          if (!bus.ENABLE) begin
            owner = -1; ph = 0;
          end else if (bus.DONE) begin
            if (bus.RESULT) begin e_winner = oh(owner); ph = 3; end
            else begin lock_end[owner] = unlock_edge(k); ph = 1; end
            owner = -1;
          end else if (k == g + ANS * HZ) begin
            e_timeout = 1'b1; lock_end[owner] = unlock_edge(k); owner = -1; ph = 1;
          end
        end
        default: if (!bus.ENABLE) ph = 0;
      endcase
      prev_req = bus.REQ;
      e_grant  = (ph == 2) ? oh(owner) : 2'b00;
      e_busy   = (ph == 2);
      e_sec    = (ph == 2) ? 4'(ANS - (k - g) / HZ) : 4'd0;
      e_locked = {k < lock_end[1], k < lock_end[0]};
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge RST_N);
    model_update();
  end

  initial forever begin
    @(negedge CLK);
    check("sb_grant",    bus.GRANT,    e_grant);
    check("sb_busy",     bus.BUSY,     e_busy);
    check("sb_timeout",  bus.TIMEOUT,  e_timeout);
    check("sb_winner",   bus.WINNER,   e_winner);
    check("sb_locked",   bus.LOCKED,   e_locked);
    check("sb_sec_left", bus.SEC_LEFT, e_sec);
  end

  // ---------------- directed stimulus
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic pulse_done(input logic r);
    bus.DONE = 1'b1; bus.RESULT = r;
    cyc(1);
    bus.DONE = 1'b0; bus.RESULT = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"},   bus.GRANT,    0);
    check({tag, "_busy"},    bus.BUSY,     0);
    check({tag, "_timeout"}, bus.TIMEOUT,  0);
    check({tag, "_winner"},  bus.WINNER,   0);
    check({tag, "_locked"},  bus.LOCKED,   0);
    check({tag, "_sec"},     bus.SEC_LEFT, 0);
  endtask

  int n;
  logic [3:0] seq [$];

  initial begin
    bus.ENABLE = 1'b0; bus.REQ = 2'b00; bus.DONE = 1'b0; bus.RESULT = 1'b0;
    #22;
    check_all_zero("reset");
    RST_N = 1'b1;
    cyc(1);

    // Simultaneous presses: pointer starts at player 0, then alternates.
    bus.ENABLE = 1'b1; cyc(2);
    bus.REQ = 2'b11; cyc(1);
    check("ptr_first_grant", bus.GRANT, 2'b01);
    bus.REQ = 2'b00;
    pulse_done(1'b1);
    check("ptr_first_winner", bus.WINNER, 2'b01);
    bus.ENABLE = 1'b0; cyc(1);
    bus.ENABLE = 1'b1; cyc(2);
    bus.REQ = 2'b11; cyc(1);
    check("ptr_second_grant", bus.GRANT, 2'b10);
    // ENABLE drops mid-answer: grant released, no pulses.
    bus.ENABLE = 1'b0; bus.REQ = 2'b00; cyc(1);
    check("endrop_grant", bus.GRANT, 2'b00);
    check("endrop_busy", bus.BUSY, 1'b0);
    check("endrop_winner", bus.WINNER, 2'b00);
    check("endrop_timeout", bus.TIMEOUT, 1'b0);
    cyc(1);

    // Basic correct answer.
    bus.ENABLE = 1'b1; cyc(2);
    bus.REQ = 2'b01; cyc(1);
    check("basic_grant", bus.GRANT, 2'b01);
    check("basic_busy", bus.BUSY, 1'b1);
    check("basic_sec", bus.SEC_LEFT, 4'd3);
    cyc(2);
    pulse_done(1'b1);
    check("basic_winner", bus.WINNER, 2'b01);
    check("basic_grant_off", bus.GRANT, 2'b00);
    cyc(1);
    check("basic_winner_1cyc", bus.WINNER, 2'b00);
    bus.ENABLE = 1'b0; bus.REQ = 2'b00; cyc(1);

    // Wrong answer locks player 0; re-press ignored; player 1 still served.
    bus.ENABLE = 1'b1; cyc(2);
    bus.REQ = 2'b01; cyc(1);
    check("wrong_grant", bus.GRANT, 2'b01);
    bus.REQ = 2'b00;
    pulse_done(1'b0);
    check("wrong_locked", bus.LOCKED, 2'b01);
    check("wrong_grant_off", bus.GRANT, 2'b00);
    bus.REQ = 2'b01; cyc(1);
    bus.REQ = 2'b00; cyc(1);
    check("locked_press_ignored", bus.GRANT, 2'b00);
    bus.REQ = 2'b10; cyc(1);
    check("other_player_grant", bus.GRANT, 2'b10);
    bus.REQ = 2'b00;
    pulse_done(1'b1);
    n = 4;
    while (bus.LOCKED[0] && n < 45) begin cyc(1); n++; end
    check("lock_release_20_30", (n >= 20 && n <= 30), 1);
    bus.ENABLE = 1'b0; cyc(1);

    // Timeout for player 1.
    bus.ENABLE = 1'b1; cyc(2);
    bus.REQ = 2'b10; cyc(1);
    check("to_grant", bus.GRANT, 2'b10);
    bus.REQ = 2'b00;
    seq.delete();
    seq.push_back(bus.SEC_LEFT);
    n = 0;
    while (!bus.TIMEOUT && n < 50) begin
      cyc(1); n++;
      if (bus.SEC_LEFT != seq[$]) seq.push_back(bus.SEC_LEFT);
    end
    check("to_latency", n, 30);
    check("to_locked", bus.LOCKED, 2'b10);
    check("to_grant_off", bus.GRANT, 2'b00);
    check("to_seq_len", seq.size(), 4);
    for (int i = 0; i < 4; i++)
      check("to_seq", (i < seq.size()) ? 32'(seq[i]) : 32'd15, 3 - i);
    cyc(1);
    check("to_pulse_1cyc", bus.TIMEOUT, 1'b0);

    // DONE on the expiry tick wins over TIMEOUT.
    bus.REQ = 2'b01; cyc(1);
    check("tie_grant", bus.GRANT, 2'b01);
    bus.REQ = 2'b00;
    cyc(29);
    pulse_done(1'b1);
    check("tie_winner", bus.WINNER, 2'b01);
    check("tie_no_timeout", bus.TIMEOUT, 1'b0);
    pulse_done(1'b0);
    check("done_outside_winner", bus.WINNER, 2'b00);
    check("done_outside_lock", bus.LOCKED[0], 1'b0);
    bus.ENABLE = 1'b0; cyc(1);

    // Held button and asynchronous reset mid-answer.
    bus.ENABLE = 1'b1; cyc(2);
    bus.REQ = 2'b11; cyc(1);
    check("held_grant", bus.GRANT, 2'b10);
    bus.REQ = 2'b01; cyc(3);
    check("held_no_steal", bus.GRANT, 2'b10);
    #1 RST_N = 1'b0;
    #1 check_all_zero("async_rst");
    cyc(2);
    RST_N = 1'b1;
    cyc(5);
    check("held_no_regrant", bus.GRANT, 2'b00);
    bus.REQ = 2'b00; cyc(1);
    bus.REQ = 2'b01; cyc(1);
    check("repress_grant", bus.GRANT, 2'b01);
    bus.ENABLE = 1'b0; bus.REQ = 2'b00; cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
